// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline hazard controller
//
// Purpose: register-address width, forward-select encodings, FSM state type,
//          shadow-entry struct and the source-match helper.
// Ports:   none (package).
package pipe_pkg;

   localparam int REG_ADDR_W = 4;

   // Operand source for the instruction entering EX
   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;
   localparam logic [1:0] FWD_WB    = 2'b11;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

   // One in-flight writer: valid, destination register, is-load
   typedef struct packed {
      logic                  v;
      logic [REG_ADDR_W-1:0] dst;
      logic                  ld;
   } shadow_t;

   // A source only matches if the ID instruction is real and actually reads it
   function automatic logic src_match(input logic                  id_valid,
                                      input logic                  uses,
                                      input shadow_t               e,
                                      input logic [REG_ADDR_W-1:0] addr);
      return id_valid & uses & e.v & (e.dst == addr);
   endfunction

endpackage

// File: rtl/pipe_shadow_stage.sv
// rtl/pipe_shadow_stage.sv - one {v, dst, ld} shadow register with bubble load
//
// Purpose: mirrors the destination info of the instruction held in one
//          pipeline stage (EX, MEM or WB).
// Ports:
//   clk      in  pipeline clock
//   reset_n  in  asynchronous active-low reset
//   i_bubble in  load an invalid entry instead of i_entry
//   i_entry  in  entry arriving from the previous stage
//   o_entry  out entry currently held
module pipe_shadow_stage
   import pipe_pkg::*;
(
   input  logic    clk,
   input  logic    reset_n,
   input  logic    i_bubble,
   input  shadow_t i_entry,
   output shadow_t o_entry
);

   shadow_t r_entry;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_entry <= '0;
      end else if (i_bubble) begin
         r_entry <= '0;
      end else begin
         r_entry <= i_entry;
      end
   end

   assign o_entry = r_entry;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hazard, flush and forwarding controller for a 5-stage pipeline
//
// Purpose: tracks in-flight destination registers (EX/MEM/WB shadow) and drives
//          PC/IF-ID hold, IF-ID flush, ID-EX bubble and operand forward selects.
//          Keeps saturating stall/flush counters and a registered RUN/STALL/FLUSH
//          state for debug.
// Build option: PIPE_HAZARD_FORWARD_EN - when defined, forwarding is active and
//          only load-use stalls; otherwise selects are 00 and every RAW stalls.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   id_valid, id_s1/s2_addr,
//   id_uses_s1/s2, id_wr_en,
//   id_d_addr, id_is_load         decoded ID-stage instruction
//   ex_redirect                   branch taken / JAL resolved in EX
//   pc_stall, ifid_stall          hold PC and IF/ID
//   ifid_flush, idex_bubble       squash IF/ID, insert NOP into ID/EX
//   fwd_s1_sel, fwd_s2_sel        operand source selects
//   stall_count, flush_count      saturating performance counters
//   dbg_state                     registered RUN/STALL/FLUSH state
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_s1_addr,
   input  logic [REG_ADDR_W-1:0] id_s2_addr,
   input  logic                  id_uses_s1,
   input  logic                  id_uses_s2,
   input  logic                  id_wr_en,
   input  logic [REG_ADDR_W-1:0] id_d_addr,
   input  logic                  id_is_load,
   input  logic                  ex_redirect,
   output logic                  pc_stall,
   output logic                  ifid_stall,
   output logic                  ifid_flush,
   output logic                  idex_bubble,
   output logic [1:0]            fwd_s1_sel,
   output logic [1:0]            fwd_s2_sel,
   output logic [CNT_W-1:0]      stall_count,
   output logic [CNT_W-1:0]      flush_count,
   output logic [1:0]            dbg_state
);

   shadow_t w_id_entry;
   shadow_t w_ex;
   shadow_t w_mem;
   shadow_t w_wb;

   logic w_s1_ex, w_s1_mem, w_s1_wb;
   logic w_s2_ex, w_s2_mem, w_s2_wb;
   logic w_hz;
   logic w_pc_stall;
   logic w_ifid_stall;
   logic w_ifid_flush;
   logic w_idex_bubble;
   logic [1:0] w_fwd_s1;
   logic [1:0] w_fwd_s2;

   state_e           r_state;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   // Load flag is irrelevant once the writer has reached WB
   logic w_unused;
   assign w_unused = &{1'b0, w_wb.ld};

   // ---------------- shadow pipeline ----------------
   assign w_id_entry = '{v: id_valid & id_wr_en, dst: id_d_addr, ld: id_is_load};

   pipe_shadow_stage u_ex (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_bubble (w_idex_bubble),
      .i_entry  (w_id_entry),
      .o_entry  (w_ex)
   );

   pipe_shadow_stage u_mem (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_bubble (1'b0),
      .i_entry  (w_ex),
      .o_entry  (w_mem)
   );

   pipe_shadow_stage u_wb (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_bubble (1'b0),
      .i_entry  (w_mem),
      .o_entry  (w_wb)
   );

   // ---------------- source matching ----------------
   assign w_s1_ex  = src_match(id_valid, id_uses_s1, w_ex,  id_s1_addr);
   assign w_s1_mem = src_match(id_valid, id_uses_s1, w_mem, id_s1_addr);
   assign w_s1_wb  = src_match(id_valid, id_uses_s1, w_wb,  id_s1_addr);
   assign w_s2_ex  = src_match(id_valid, id_uses_s2, w_ex,  id_s2_addr);
   assign w_s2_mem = src_match(id_valid, id_uses_s2, w_mem, id_s2_addr);
   assign w_s2_wb  = src_match(id_valid, id_uses_s2, w_wb,  id_s2_addr);

`ifdef PIPE_HAZARD_FORWARD_EN
   // Only a load in EX cannot be forwarded in time: its data appears after MEM
   assign w_hz = (w_s1_ex | w_s2_ex) & w_ex.ld;

   // Youngest producer wins; selects are meaningless during a stall
   always_comb begin
      w_fwd_s1 = FWD_RF;
      w_fwd_s2 = FWD_RF;
      if (!w_hz) begin
         if (w_s1_ex)       w_fwd_s1 = FWD_EXMEM;
         else if (w_s1_mem) w_fwd_s1 = FWD_MEMWB;
         else if (w_s1_wb)  w_fwd_s1 = FWD_WB;
         if (w_s2_ex)       w_fwd_s2 = FWD_EXMEM;
         else if (w_s2_mem) w_fwd_s2 = FWD_MEMWB;
         else if (w_s2_wb)  w_fwd_s2 = FWD_WB;
      end
   end
`else
   // No bypass and no write-through: wait until the writer has left WB
   assign w_hz = w_s1_ex | w_s1_mem | w_s1_wb | w_s2_ex | w_s2_mem | w_s2_wb;

   always_comb begin
      w_fwd_s1 = FWD_RF;
      w_fwd_s2 = FWD_RF;
   end
`endif

   // ---------------- control ----------------
   // Redirect wins: IF and ID hold wrong-path instructions, so their hazard is moot
   always_comb begin
      w_pc_stall    = 1'b0;
      w_ifid_stall  = 1'b0;
      w_ifid_flush  = 1'b0;
      w_idex_bubble = 1'b0;
      if (ex_redirect) begin
         w_ifid_flush  = 1'b1;
         w_idex_bubble = 1'b1;
      end else if (w_hz) begin
         w_pc_stall    = 1'b1;
         w_ifid_stall  = 1'b1;
         w_idex_bubble = 1'b1;
      end
   end

   // ---------------- FSM and counters ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_RUN;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (ex_redirect) begin
         r_state <= ST_FLUSH;
         if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end else if (w_hz) begin
         r_state <= ST_STALL;
         if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end else begin
         r_state <= ST_RUN;
      end
   end

   assign pc_stall    = w_pc_stall;
   assign ifid_stall  = w_ifid_stall;
   assign ifid_flush  = w_ifid_flush;
   assign idex_bubble = w_idex_bubble;
   assign fwd_s1_sel  = w_fwd_s1;
   assign fwd_s2_sel  = w_fwd_s2;
   assign stall_count = r_stall_cnt;
   assign flush_count = r_flush_cnt;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

   localparam int CNT_W = 4;
   localparam int CMAX  = 15;
`ifdef PIPE_HAZARD_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset_n;
   logic             id_valid;
   logic [3:0]       id_s1_addr;
   logic [3:0]       id_s2_addr;
   logic             id_uses_s1;
   logic             id_uses_s2;
   logic             id_wr_en;
   logic [3:0]       id_d_addr;
   logic             id_is_load;
   logic             ex_redirect;
   logic             pc_stall;
   logic             ifid_stall;
   logic             ifid_flush;
   logic             idex_bubble;
   logic [1:0]       fwd_s1_sel;
   logic [1:0]       fwd_s2_sel;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;
   logic [1:0]       dbg_state;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .id_valid    (id_valid),
      .id_s1_addr  (id_s1_addr),
      .id_s2_addr  (id_s2_addr),
      .id_uses_s1  (id_uses_s1),
      .id_uses_s2  (id_uses_s2),
      .id_wr_en    (id_wr_en),
      .id_d_addr   (id_d_addr),
      .id_is_load  (id_is_load),
      .ex_redirect (ex_redirect),
      .pc_stall    (pc_stall),
      .ifid_stall  (ifid_stall),
      .ifid_flush  (ifid_flush),
      .idex_bubble (idex_bubble),
      .fwd_s1_sel  (fwd_s1_sel),
      .fwd_s2_sel  (fwd_s2_sel),
      .stall_count (stall_count),
      .flush_count (flush_count),
      .dbg_state   (dbg_state)
   );

   // Reference model: history of writers that entered EX, index 0 = most recent
   typedef struct {
      bit v;
      int dst;
      bit ld;
   } ent_t;

   typedef struct {
      bit pc_stall;
      bit ifid_stall;
      bit flush;
      bit bubble;
      int fwd1;
      int fwd2;
      bit chk_fwd;
      int scnt;
      int fcnt;
      int state;
   } exp_t;

   ent_t hist[$];
   exp_t exp_q[$];
   int   m_scnt;
   int   m_fcnt;
   int   m_kind;   // 0 normal, 1 stalled, 2 redirected (previous cycle)
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
      end
   endtask

   task automatic model_clear();
      ent_t z;
      z = '{v: 1'b0, dst: 0, ld: 1'b0};
      hist.delete();
      repeat (3) hist.push_back(z);
      m_scnt = 0;
      m_fcnt = 0;
      m_kind = 0;
   endtask

   // Age of the youngest in-flight writer of addr (0 = EX, 1 = MEM, 2 = WB), -1 if none
   function automatic int age_of(input bit v, input bit use_it, input int addr);
      if (!(v && use_it)) return -1;
      for (int a = 0; a < 3; a++)
         if (hist[a].v && hist[a].dst == addr) return a;
      return -1;
   endfunction

   // Monitor: compare every presented cycle against the queued expectation
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("pc_stall",    int'(pc_stall),    int'(e.pc_stall));
         check("ifid_stall",  int'(ifid_stall),  int'(e.ifid_stall));
         check("ifid_flush",  int'(ifid_flush),  int'(e.flush));
         check("idex_bubble", int'(idex_bubble), int'(e.bubble));
         check("stall_count", int'(stall_count), e.scnt);
         check("flush_count", int'(flush_count), e.fcnt);
         check("dbg_state",   int'(dbg_state),   e.state);
         if (e.chk_fwd) begin
            check("fwd_s1_sel", int'(fwd_s1_sel), e.fwd1);
            check("fwd_s2_sel", int'(fwd_s2_sel), e.fwd2);
         end
      end
   end

   task automatic drive_idle();
      id_valid = 0; id_s1_addr = 0; id_s2_addr = 0; id_uses_s1 = 0; id_uses_s2 = 0;
      id_wr_en = 0; id_d_addr = 0; id_is_load = 0; ex_redirect = 0;
   endtask

   // Assert reset between edges and hold it over one rising edge
   task automatic rst_cycle();
      exp_t e;
      reset_n = 1'b0;
      drive_idle();
      model_clear();
      e = '{pc_stall: 0, ifid_stall: 0, flush: 0, bubble: 0, fwd1: 0, fwd2: 0,
            chk_fwd: 1, scnt: 0, fcnt: 0, state: 0};
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // One cycle of ID/EX stimulus; returns whether the model predicts a stall
   task automatic step(input bit v, input int s1, input int s2, input bit u1, input bit u2,
                       input bit wr, input int d, input bit ld, input bit rd,
                       output bit stalled);
      exp_t e;
      ent_t n;
      int   a1, a2;
      bit   hz;
      reset_n     = 1'b1;
      id_valid    = v;
      id_s1_addr  = 4'(s1);
      id_s2_addr  = 4'(s2);
      id_uses_s1  = u1;
      id_uses_s2  = u2;
      id_wr_en    = wr;
      id_d_addr   = 4'(d);
      id_is_load  = ld;
      ex_redirect = rd;
      a1 = age_of(v, u1, s1);
      a2 = age_of(v, u2, s2);
      if (FWD) hz = (a1 == 0 || a2 == 0) && hist[0].ld;
      else     hz = (a1 >= 0) || (a2 >= 0);
      e.pc_stall   = !rd && hz;
      e.ifid_stall = !rd && hz;
      e.flush      = rd;
      e.bubble     = rd || hz;
      e.fwd1       = (FWD && !hz && a1 >= 0) ? a1 + 1 : 0;
      e.fwd2       = (FWD && !hz && a2 >= 0) ? a2 + 1 : 0;
      e.chk_fwd    = !rd;
      e.scnt       = m_scnt;
      e.fcnt       = m_fcnt;
      e.state      = m_kind;
      exp_q.push_back(e);
      stalled = !rd && hz;
      @(posedge clk);
      if (e.bubble) n = '{v: 1'b0, dst: 0, ld: 1'b0};
      else          n = '{v: v && wr, dst: d, ld: ld};
      hist.push_front(n);
      void'(hist.pop_back());
      if (rd) begin
         if (m_fcnt < CMAX) m_fcnt++;
         m_kind = 2;
      end else if (hz) begin
         if (m_scnt < CMAX) m_scnt++;
         m_kind = 1;
      end else begin
         m_kind = 0;
      end
      #1;
   endtask

   // Present one instruction until it is accepted; report the stall cycles
   task automatic hold_issue(input int s1, input int s2, input bit u1, input bit u2,
                             input int d, input bit ld, output int nstall);
      bit st;
      bit done;
      nstall = 0;
      done   = 0;
      for (int k = 0; k < 8 && !done; k++) begin
         step(1, s1, s2, u1, u2, 1, d, ld, 0, st);
         if (st) nstall++;
         else    done = 1;
      end
      if (!done) check("hold_bound", nstall, -1);
   endtask

   task automatic idle(input int n);
      bit st;
      repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0, st);
   endtask

   initial begin
      bit st;
      int ns;
      drive_idle();
      reset_n = 1'b0;
      model_clear();
      @(posedge clk);
      #1;
      rst_cycle();
      rst_cycle();

      // Load r3, then add r4 = r3 + r1 adjacent
      step(1, 0, 0, 0, 0, 1, 3, 1, 0, st);
      hold_issue(3, 1, 1, 1, 4, 0, ns);
      check("load_use_stalls", ns, FWD ? 1 : 3);
      idle(4);

      // ALU producer r5, adjacent consumer
      step(1, 0, 0, 0, 0, 1, 5, 0, 0, st);
      hold_issue(5, 2, 1, 1, 6, 0, ns);
      check("alu_adj_stalls", ns, FWD ? 0 : 3);
      idle(4);

      // ALU producer r5, consumer at distance 4
      step(1, 0, 0, 0, 0, 1, 5, 0, 0, st);
      step(1, 0, 0, 0, 0, 1, 9, 0, 0, st);
      step(1, 0, 0, 0, 0, 1, 9, 0, 0, st);
      step(1, 0, 0, 0, 0, 1, 9, 0, 0, st);
      hold_issue(5, 0, 1, 0, 7, 0, ns);
      check("alu_dist4_stalls", ns, 0);
      idle(4);

      // Redirect while ID holds a load-use hazard
      step(1, 0, 0, 0, 0, 1, 3, 1, 0, st);
      step(1, 3, 1, 1, 1, 1, 4, 0, 1, st);
      check("redirect_no_stall", int'(st), 0);
      idle(4);

      // s2 address matches a pending load but is not read
      step(1, 0, 0, 0, 0, 1, 6, 1, 0, st);
      hold_issue(1, 6, 1, 0, 8, 0, ns);
      check("unused_s2_stalls", ns, 0);
      idle(4);

      // Reset mid-stall, then the first dependent pair again
      step(1, 0, 0, 0, 0, 1, 3, 1, 0, st);
      step(1, 3, 1, 1, 1, 1, 4, 0, 0, st);
      rst_cycle();
      hold_issue(0, 0, 0, 0, 3, 1, ns);
      hold_issue(3, 1, 1, 1, 4, 0, ns);
      check("post_reset_stalls", ns, FWD ? 1 : 3);
      idle(3);

      // Randomized traffic; small register range keeps hazards frequent
      for (int i = 0; i < 600; i++) begin
         step(($urandom % 8) != 0,
              int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
              $urandom % 2, $urandom % 2, ($urandom % 4) != 0,
              int'($urandom_range(0, 5)), ($urandom % 3) == 0,
              ($urandom % 10) == 0, st);
      end
      idle(2);

      repeat (3) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
